sha256_stream: RTL
==================

SHA256_STREAM -- requirements
Module: sha256_stream

Interface
REQ-001 Parameter BEAT_BYTES, default 4, sets input bytes per beat; legal values are 1, 2 and 4.
REQ-002 Parameter LEN_W, default 32, sets the width of the message byte counter; the maximum message length is 2^LEN_W-1 bytes.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset; it SHALL be asynchronous and active-high.
REQ-005 Port in_valid  input  1  SHALL indicate that the input beat is valid.
REQ-006 Port in_ready  output  1  SHALL indicate that the core accepts a beat; a beat transfers when in_valid&&in_ready are high at a rising edge.
REQ-007 Port in_data  input  8*BEAT_BYTES  carries message bytes; the first byte SHALL be in the MSBs.
REQ-008 Port in_last  input  1  SHALL mark the final beat of a message.
REQ-009 Port in_nbytes  input  3  gives the count of valid MSB-aligned bytes on the last beat (0..BEAT_BYTES); it SHALL be ignored on non-last beats, which are always full.
REQ-010 Port digest  output  256  carries H0..H7, with H0 in bits [255:224].
REQ-011 Port digest_valid  output  1  SHALL indicate that digest holds a completed hash.
REQ-012 Port busy  output  1  SHALL be high in every state except IDLE and LOAD.
REQ-013 Port err  output  1  SHALL flag a length overflow.

Function
REQ-014 States SHALL be IDLE, LOAD, PAD, ROUND, UPDATE and DONE, with one SHA-256 round per clock in ROUND.
REQ-015 in_ready SHALL be 1 in IDLE, LOAD and DONE, and 0 in PAD, ROUND and UPDATE.
REQ-016 The first beat accepted in IDLE or DONE SHALL:
- load H with the FIPS 180-4 initial values;
- clear the byte counter;
- drop digest_valid and err;
- enter LOAD.
REQ-017 Beats SHALL pack into a 16-word block buffer; 64 is a multiple of BEAT_BYTES, so a beat never straddles blocks.
REQ-018 When a non-last beat fills the buffer, the next state SHALL be ROUND.
REQ-019 On a last beat, the next state SHALL be PAD, which in one cycle:
- appends 0x80 after the last valid byte;
- zero-fills;
- writes the 64-bit big-endian bit length (bytes*8) into words 14-15 if it fits (≤55 data bytes in the block), otherwise marks an extra length-only block.
REQ-020 If the last beat exactly fills the buffer, that block SHALL be processed first and PAD then builds a block of 0x80, zeros and the length.
REQ-021 An empty message (in_last with in_nbytes=0 as the first beat) SHALL hash to the empty-string digest.
REQ-022 ROUND SHALL last exactly 64 cycles; the message schedule W[t] is computed on the fly from a 16-word sliding window; all additions are mod 2^32.
REQ-023 UPDATE (1 cycle) SHALL add a..h into H0..H7 mod 2^32, then go to:
- PAD, if an extra block is pending;
- DONE, if the message is complete;
- LOAD, otherwise.
REQ-024 Latency: a last-beat handshake at edge t gives PAD at t+1, ROUND at t+2..t+65, UPDATE at t+66, and digest_valid=1 from t+67; each extra pad block adds 66 cycles.
REQ-025 In DONE, digest and digest_valid SHALL hold until the next accepted beat or rst.
REQ-026 in_nbytes>BEAT_BYTES SHALL be treated as BEAT_BYTES.
REQ-027 If an accepted beat would push the byte count past 2^LEN_W-1:
- err SHALL go high;
- the message is discarded;
- the state SHALL return to IDLE;
- digest_valid SHALL stay 0.
REQ-028 in_valid low in LOAD SHALL stall the core with no state change; there is no timeout.

Reset
REQ-029 While rst=1, and immediately on assertion, the core SHALL force:
- state=IDLE;
- digest=0, digest_valid=0, err=0, busy=0;
- in_ready=0;
- the buffer, counter and working registers cleared.
REQ-030 On the first edge after rst deasserts, in_ready SHALL be 1.
REQ-031 rst asserted in any state, including mid-ROUND, SHALL abort the message with no partial digest ever shown.

Verification
REQ-032 Stimulus "abc" (BEAT_BYTES=4, one beat 0x61626300, in_nbytes=3, last) -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, with digest_valid exactly 67 cycles after the handshake.
REQ-033 Stimulus empty message (in_nbytes=0, last) -> digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-034 Stimulus 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, with two blocks processed and busy high across both.
REQ-035 Stimulus "abc" then "aaa" back-to-back from DONE -> second digest 9834876dcfb05cb167a5c24953eba58c4ac89b1adf57f28f2f9d09af107ee8f0, and digest_valid low between the messages.
REQ-036 Stimulus rst pulsed at round 30 of "aaa", then "abc" -> outputs zero immediately, then the correct "abc" digest.
REQ-037 Stimulus LEN_W=4, 20-byte message with BEAT_BYTES=1 -> err=1 on the 16th byte, then IDLE with in_ready=1 and digest_valid=0.

Source files
------------

// File: rtl/sha256_stream.sv
// Streaming SHA-256 core: packs byte beats into 512-bit blocks, pads in hardware,
// and runs one compression round per clock. Digest is shown only while valid.
module sha256_stream #(
  parameter int unsigned BEAT_BYTES = 4,
  parameter int unsigned LEN_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*BEAT_BYTES-1:0] in_data,
  input  logic                    in_last,
  input  logic [2:0]              in_nbytes,
  output logic [255:0]            digest,
  output logic                    digest_valid,
  output logic                    busy,
  output logic                    err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_e;

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_e             state_q, state_d;
  logic               rdy_en_q;
  logic [0:7][31:0]   h_q, h_d;
  logic [0:7][31:0]   wk_q, wk_d;
  logic [0:15][31:0]  w_q, w_d;
  logic [5:0]         rnd_q, rnd_d;
  logic [5:0]         wptr_q, wptr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               pad80_q, pad80_d;
  logic               final_q, final_d;
  logic               dv_q, dv_d;
  logic               err_q, err_d;

  logic               accept;
  logic [2:0]         nb_eff;
  logic [2:0]         beat_n;
  logic [LEN_W-1:0]   base_cnt;
  logic [5:0]         base_wptr;
  logic [LEN_W:0]     sum;
  logic [6:0]         fill;
  logic [63:0]        len64;
  logic [0:3][7:0]    beat4;
  logic [0:63][7:0]   blk;
  logic [31:0]        t1, t2, w_new;

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    wk_d      = wk_q;
    w_d       = w_q;
    rnd_d     = rnd_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    pad80_d   = pad80_q;
    final_d   = final_q;
    dv_d      = dv_q;
    err_d     = err_q;

    blk       = w_q;
    accept    = in_valid && in_ready;
    nb_eff    = (in_nbytes > 3'(BEAT_BYTES)) ? 3'(BEAT_BYTES) : in_nbytes;
    beat_n    = in_last ? nb_eff : 3'(BEAT_BYTES);
    base_cnt  = (state_q == S_LOAD) ? cnt_q : '0;
    base_wptr = (state_q == S_LOAD) ? wptr_q : '0;
    sum       = {1'b0, base_cnt} + (LEN_W+1)'(beat_n);
    fill      = {1'b0, base_wptr} + 7'(beat_n);
    len64     = 64'(cnt_q) << 3;
    beat4     = 32'(in_data) << (8 * (4 - BEAT_BYTES));

    t1 = wk_q[7] + bsig1(wk_q[4]) + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
       + K_TAB[rnd_q] + w_q[0];
    t2 = bsig0(wk_q[0]) + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
    // The block buffer doubles as the schedule window: w_q[0] is always W[t].
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

    case (state_q)
      S_IDLE, S_LOAD, S_DONE: begin
        if (accept) begin
          if (state_q != S_LOAD) begin
            h_d     = H_INIT;
            dv_d    = 1'b0;
            err_d   = 1'b0;
            last_d  = 1'b0;
            pad80_d = 1'b0;
            final_d = 1'b0;
          end
          if (sum[LEN_W]) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
            wptr_d  = '0;
          end else begin
            for (int unsigned k = 0; k < BEAT_BYTES; k++) begin
              blk[6'(base_wptr + k)] = beat4[2'(k)];
            end
            w_d    = blk;
            cnt_d  = sum[LEN_W-1:0];
            wptr_d = fill[5:0];
            last_d = in_last;
            if (fill[6]) begin
              state_d = S_ROUND;
              wk_d    = h_d;
              rnd_d   = '0;
            end else begin
              state_d = in_last ? S_PAD : S_LOAD;
            end
          end
        end
      end

      S_PAD: begin
        // Once 0x80 has been placed, later pad blocks are zeros plus the length.
        for (int unsigned i = 0; i < 64; i++) begin
          if (pad80_q || i > 32'(wptr_q)) begin
            blk[6'(i)] = 8'h00;
          end else if (i == 32'(wptr_q)) begin
            blk[6'(i)] = 8'h80;
          end
        end
        if (wptr_q <= 6'd55) begin
          blk[56:63] = len64;
          final_d    = 1'b1;
        end
        w_d     = blk;
        pad80_d = 1'b1;
        wptr_d  = '0;
        wk_d    = h_q;
        rnd_d   = '0;
        state_d = S_ROUND;
      end

      S_ROUND: begin
        wk_d[0]    = t1 + t2;
        wk_d[1]    = wk_q[0];
        wk_d[2]    = wk_q[1];
        wk_d[3]    = wk_q[2];
        wk_d[4]    = wk_q[3] + t1;
        wk_d[5]    = wk_q[4];
        wk_d[6]    = wk_q[5];
        wk_d[7]    = wk_q[6];
        w_d[0:14]  = w_q[1:15];
        w_d[15]    = w_new;
        rnd_d      = rnd_q + 6'd1;
        if (rnd_q == 6'd63) begin
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        for (int unsigned i = 0; i < 8; i++) begin
          h_d[3'(i)] = h_q[3'(i)] + wk_q[3'(i)];
        end
        if (final_q) begin
          state_d = S_DONE;
          dv_d    = 1'b1;
        end else if (last_q) begin
          state_d = S_PAD;
        end else begin
          state_d = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
      h_q      <= '0;
      wk_q     <= '0;
      w_q      <= '0;
      rnd_q    <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      pad80_q  <= 1'b0;
      final_q  <= 1'b0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      h_q      <= h_d;
      wk_q     <= wk_d;
      w_q      <= w_d;
      rnd_q    <= rnd_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      pad80_q  <= pad80_d;
      final_q  <= final_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
    end
  end

  assign in_ready     = rdy_en_q &&
                        (state_q == S_IDLE || state_q == S_LOAD || state_q == S_DONE);
  assign busy         = !(state_q == S_IDLE || state_q == S_LOAD);
  assign digest       = dv_q ? h_q : '0;
  assign digest_valid = dv_q;
  assign err          = err_q;

endmodule
